// File: rtl/audio_adc_rx.sv
// I2S capture master for the WM8731 ADC path: generates bclk/adclrck, deserialises
// adcdat into 16-bit left/right words and offers each stereo frame on valid/ready.
module audio_adc_rx #(
    parameter int BCLK_HALF = 3,
    parameter int SLOT_BITS = 32,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk_aud_ref,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 adcdat,
    output logic                 bclk,
    output logic                 adclrck,
    output logic [WORD_BITS-1:0] audio_l,
    output logic [WORD_BITS-1:0] audio_r,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    input  logic                 ovr_clr
);

    // Handshake: a frame moves downstream in every cycle where sample_valid and
    // sample_ready are both high; sample_valid never drops without such a transfer
    // except on reset, and a new frame replaces an unaccepted one (flagging overrun).

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] WORD_LEN = BIT_W'(WORD_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic [WORD_BITS-1:0] l_stage;
    logic                 load_pend;

    logic                 tick;
    logic                 bclk_rise;
    logic                 bclk_fall;
    logic                 frame_wrap;
    logic [BIT_W-1:0]     bit_nxt;
    logic                 right_slot;
    logic [BIT_W-1:0]     slot_pos;
    logic                 data_bit;
    logic                 word_end;
    logic [WORD_BITS-1:0] shift_nxt;
    logic                 xfer;
    logic                 ovr_set;

    always_comb begin
        tick       = (state == RUN) && (div_cnt == DIV_LAST);
        bclk_rise  = tick && !bclk;
        bclk_fall  = tick && bclk;
        bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        frame_wrap = bclk_fall && (bit_cnt == BIT_LAST);
        right_slot = (bit_cnt >= SLOT_LEN);
        slot_pos   = right_slot ? (bit_cnt - SLOT_LEN) : bit_cnt;
        // Position 0 is the I2S delay bit; positions past the word are padding.
        data_bit   = (slot_pos != '0) && (slot_pos <= WORD_LEN);
        word_end   = (slot_pos == WORD_LEN);
        shift_nxt  = {shift_reg[WORD_BITS-2:0], adcdat};
        xfer       = sample_valid && sample_ready;
        ovr_set    = load_pend && sample_valid && !sample_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en) state_nxt = RUN;
            RUN:  if (frame_wrap && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_aud_ref) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Bit clock, frame clock and capture path.
    always_ff @(posedge clk_aud_ref) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            bclk      <= 1'b0;
            adclrck   <= 1'b0;
            shift_reg <= '0;
            l_stage   <= '0;
            load_pend <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            if (state == RUN) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) bclk <= ~bclk;
                if (bclk_fall) begin
                    bit_cnt <= bit_nxt;
                    adclrck <= (bit_nxt >= SLOT_LEN);
                end
                if (bclk_rise && data_bit) begin
                    shift_reg <= shift_nxt;
                    if (word_end) begin
                        if (right_slot) load_pend <= 1'b1;
                        else            l_stage   <= shift_nxt;
                    end
                end
            end
        end
    end

    // Output frame register; the right word is still in shift_reg one cycle later.
    always_ff @(posedge clk_aud_ref) begin
        if (rst) begin
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load_pend) begin
                audio_l      <= l_stage;
                audio_r      <= shift_reg;
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule
